// File: rtl/aidc_burst_splitter.sv
// aidc_burst_splitter
//   AXI4 address-channel sequencer between the core and the memory
//   subsystem. Each INCR request with alen==15 (16 beats) goes out as two
//   8-beat sub-bursts. Every other request passes through unchanged. For
//   every accepted core request a one-bit split tag is pushed into a small
//   FIFO, which the downstream response merger pops.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both high. A valid source holds its payload stable until that edge.
//   core_aready never depends combinationally on mem_aready or tag_ready.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   core_a*                     request from the core (valid/ready)
//   mem_a*                      registered request to memory (valid/ready)
//   tag_valid/ready/split       split-tag FIFO head (pop on valid && ready)
//   tag_count                   FIFO occupancy, 0..TAG_DEPTH
//   err_unsup                   sticky: FIXED/WRAP request with alen>7 seen
//   perf_split_cnt/pass_cnt     saturating counters of accepted split and
//                               non-split requests (only with
//                               AIDC_SPLIT_PERF_EN defined)
module aidc_burst_splitter #(
   parameter int ADDR_W    = 32,
   parameter int ID_W      = 4,
   parameter int TAG_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           core_avalid,
   output logic                           core_aready,
   input  logic [ID_W-1:0]                core_aid,
   input  logic [ADDR_W-1:0]              core_aaddr,
   input  logic [7:0]                     core_alen,
   input  logic [2:0]                     core_asize,
   input  logic [1:0]                     core_aburst,
   output logic                           mem_avalid,
   input  logic                           mem_aready,
   output logic [ID_W-1:0]                mem_aid,
   output logic [ADDR_W-1:0]              mem_aaddr,
   output logic [7:0]                     mem_alen,
   output logic [2:0]                     mem_asize,
   output logic [1:0]                     mem_aburst,
   output logic                           tag_valid,
   input  logic                           tag_ready,
   output logic                           tag_split,
   output logic [$clog2(TAG_DEPTH):0]     tag_count,
   output logic                           err_unsup
`ifdef AIDC_SPLIT_PERF_EN
   ,
   output logic [31:0]                    perf_split_cnt,
   output logic [31:0]                    perf_pass_cnt
`endif
);

   localparam int PW = $clog2(TAG_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

   state_t              state_q, state_d;
   logic                mem_avalid_q, mem_avalid_d;
   logic [ID_W-1:0]     mem_aid_q, mem_aid_d;
   logic [ADDR_W-1:0]   mem_aaddr_q, mem_aaddr_d;
   logic [7:0]          mem_alen_q, mem_alen_d;
   logic [2:0]          mem_asize_q, mem_asize_d;
   logic [1:0]          mem_aburst_q, mem_aburst_d;
   logic                split_q, split_d;
   logic                err_q, err_d;

   logic                tag_mem_q [TAG_DEPTH];
   logic                tag_mem_d [TAG_DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;

   logic fifo_full, fifo_empty, accept, push, pop, split_new;

   assign fifo_full  = (count_q == CW'(TAG_DEPTH));
   assign fifo_empty = (count_q == '0);
   // rst_n gating keeps ready low while reset is held.
   assign core_aready = rst_n && (state_q == IDLE) && !fifo_full;
   assign accept      = core_avalid && core_aready;
   assign split_new   = (core_alen == 8'hF) && (core_aburst == 2'b01);
   assign push        = accept;
   assign pop         = tag_ready && !fifo_empty;

   // Request FSM. The mem_* registers double as the request latch; in SEND1
   // the address register is advanced by one sub-burst (8 beats of asize).
   always_comb begin
      state_d      = state_q;
      mem_avalid_d = mem_avalid_q;
      mem_aid_d    = mem_aid_q;
      mem_aaddr_d  = mem_aaddr_q;
      mem_alen_d   = mem_alen_q;
      mem_asize_d  = mem_asize_q;
      mem_aburst_d = mem_aburst_q;
      split_d      = split_q;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               mem_avalid_d = 1'b1;
               mem_aid_d    = core_aid;
               mem_aaddr_d  = core_aaddr;
               mem_alen_d   = split_new ? 8'h7 : core_alen;
               mem_asize_d  = core_asize;
               mem_aburst_d = core_aburst;
               split_d      = split_new;
               if ((core_aburst != 2'b01) && (core_alen > 8'h7)) err_d = 1'b1;
               state_d      = SEND0;
            end
         end
         SEND0: begin
            if (mem_aready) begin
               if (split_q) begin
                  mem_aaddr_d = mem_aaddr_q + (ADDR_W'(8) << mem_asize_q);
                  state_d     = SEND1;
               end else begin
                  mem_avalid_d = 1'b0;
                  state_d      = IDLE;
               end
            end
         end
         SEND1: begin
            if (mem_aready) begin
               mem_avalid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            mem_avalid_d = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   // Tag FIFO. Push and pop in the same cycle leave the count unchanged.
   always_comb begin
      tag_mem_d = tag_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push) begin
         tag_mem_d[wr_ptr_q] = split_new;
         wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mem_avalid_q <= 1'b0;
         mem_aid_q    <= '0;
         mem_aaddr_q  <= '0;
         mem_alen_q   <= '0;
         mem_asize_q  <= '0;
         mem_aburst_q <= '0;
         split_q      <= 1'b0;
         err_q        <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_avalid_q <= mem_avalid_d;
         mem_aid_q    <= mem_aid_d;
         mem_aaddr_q  <= mem_aaddr_d;
         mem_alen_q   <= mem_alen_d;
         mem_asize_q  <= mem_asize_d;
         mem_aburst_q <= mem_aburst_d;
         split_q      <= split_d;
         err_q        <= err_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         tag_mem_q    <= tag_mem_d;
      end
   end

   assign mem_avalid = mem_avalid_q;
   assign mem_aid    = mem_aid_q;
   assign mem_aaddr  = mem_aaddr_q;
   assign mem_alen   = mem_alen_q;
   assign mem_asize  = mem_asize_q;
   assign mem_aburst = mem_aburst_q;
   assign tag_valid  = !fifo_empty;
   assign tag_split  = !fifo_empty && tag_mem_q[rd_ptr_q];
   assign tag_count  = count_q;
   assign err_unsup  = err_q;

`ifdef AIDC_SPLIT_PERF_EN
   logic [31:0] split_cnt_q, split_cnt_d, pass_cnt_q, pass_cnt_d;

   always_comb begin
      split_cnt_d = split_cnt_q;
      pass_cnt_d  = pass_cnt_q;
      if (accept && split_new && (split_cnt_q != 32'hFFFF_FFFF))
         split_cnt_d = split_cnt_q + 32'd1;
      if (accept && !split_new && (pass_cnt_q != 32'hFFFF_FFFF))
         pass_cnt_d = pass_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         split_cnt_q <= '0;
         pass_cnt_q  <= '0;
      end else begin
         split_cnt_q <= split_cnt_d;
         pass_cnt_q  <= pass_cnt_d;
      end
   end

   assign perf_split_cnt = split_cnt_q;
   assign perf_pass_cnt  = pass_cnt_q;
`endif

endmodule

// File: tb/tb_aidc_burst_splitter.sv
module tb_aidc_burst_splitter;
   localparam int ADDR_W = 32;
   localparam int ID_W = 4;
   localparam int DEPTH = 8;
   localparam int PW = 49;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic core_avalid = 1'b0;
   logic core_aready;
   logic [ID_W-1:0] core_aid = '0;
   logic [ADDR_W-1:0] core_aaddr = '0;
   logic [7:0] core_alen = '0;
   logic [2:0] core_asize = '0;
   logic [1:0] core_aburst = '0;
   logic mem_avalid;
   logic mem_aready = 1'b0;
   logic [ID_W-1:0] mem_aid;
   logic [ADDR_W-1:0] mem_aaddr;
   logic [7:0] mem_alen;
   logic [2:0] mem_asize;
   logic [1:0] mem_aburst;
   logic tag_valid;
   logic tag_ready = 1'b0;
   logic tag_split;
   logic [$clog2(DEPTH):0] tag_count;
   logic err_unsup;
`ifdef AIDC_SPLIT_PERF_EN
   logic [31:0] perf_split_cnt, perf_pass_cnt;
`endif

   aidc_burst_splitter #(.ADDR_W(ADDR_W), .ID_W(ID_W), .TAG_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_avalid(core_avalid), .core_aready(core_aready), .core_aid(core_aid),
      .core_aaddr(core_aaddr), .core_alen(core_alen), .core_asize(core_asize),
      .core_aburst(core_aburst),
      .mem_avalid(mem_avalid), .mem_aready(mem_aready), .mem_aid(mem_aid),
      .mem_aaddr(mem_aaddr), .mem_alen(mem_alen), .mem_asize(mem_asize),
      .mem_aburst(mem_aburst),
      .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_split(tag_split),
      .tag_count(tag_count), .err_unsup(err_unsup)
`ifdef AIDC_SPLIT_PERF_EN
      , .perf_split_cnt(perf_split_cnt), .perf_pass_cnt(perf_pass_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int hs_cnt = 0;
   bit rand_mode = 1'b0;

   // Reference model: expected memory requests, expected tags, sticky error.
   logic [PW-1:0] exp_q[$];
   logic tag_m[$];
   logic err_m = 1'b0;
   logic prev_stall = 1'b0;
   logic [PW-1:0] prev_fields = '0;

   function automatic logic [PW-1:0] pk(logic [ID_W-1:0] id, logic [ADDR_W-1:0] a,
                                        logic [7:0] l, logic [2:0] s, logic [1:0] b);
      return {id, a, l, s, b};
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor sampled on the falling edge; inputs change #1 after the rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         tag_m.delete();
         err_m = 1'b0;
         prev_stall = 1'b0;
      end else begin
         chk("core_aready", core_aready, (!mem_avalid && tag_m.size() < DEPTH));
         chk("tag_count", tag_count, tag_m.size());
         chk("tag_valid", tag_valid, tag_m.size() != 0);
         chk("tag_split", tag_split, (tag_m.size() != 0) ? tag_m[0] : 1'b0);
         chk("err_unsup", err_unsup, err_m);
         if (prev_stall) begin
            chk("stable_valid", mem_avalid, 1'b1);
            chk("stable_fields", pk(mem_aid, mem_aaddr, mem_alen, mem_asize, mem_aburst), prev_fields);
         end
         if (mem_avalid && mem_aready) begin
            hs_cnt++;
            if (exp_q.size() == 0) chk("unexpected_mem_req", 1, 0);
            else chk("mem_req", pk(mem_aid, mem_aaddr, mem_alen, mem_asize, mem_aburst), exp_q.pop_front());
         end
         prev_stall = mem_avalid && !mem_aready;
         prev_fields = pk(mem_aid, mem_aaddr, mem_alen, mem_asize, mem_aburst);
         if (tag_valid && tag_ready && tag_m.size() != 0) void'(tag_m.pop_front());
         if (core_avalid && core_aready) begin
            if (core_aburst == 2'b01 && core_alen == 8'd15) begin
               exp_q.push_back(pk(core_aid, core_aaddr, 8'd7, core_asize, core_aburst));
               exp_q.push_back(pk(core_aid, core_aaddr + (32'd8 << core_asize), 8'd7, core_asize, core_aburst));
               tag_m.push_back(1'b1);
            end else begin
               exp_q.push_back(pk(core_aid, core_aaddr, core_alen, core_asize, core_aburst));
               tag_m.push_back(1'b0);
               if (core_aburst != 2'b01 && core_alen > 8'd7) err_m = 1'b1;
            end
         end
      end
   end

   // Random backpressure on the memory and tag sides.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) begin
            mem_aready = ($urandom_range(0, 3) != 0);
            tag_ready  = ($urandom_range(0, 1) != 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_accept();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!core_aready && n < 500);
      if (!core_aready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1 core_avalid = 1'b0;
   endtask

   task automatic send_req(logic [ID_W-1:0] id, logic [ADDR_W-1:0] a, logic [7:0] l,
                           logic [2:0] s, logic [1:0] b);
      @(posedge clk);
      #1;
      core_aid = id; core_aaddr = a; core_alen = l; core_asize = s; core_aburst = b;
      core_avalid = 1'b1;
      wait_accept();
   endtask

   task automatic idle_cycles(int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int hs0;
      // Reset values while reset is held.
      #12;
      chk("rst_core_aready", core_aready, 0);
      chk("rst_mem_avalid", mem_avalid, 0);
      chk("rst_mem_fields", pk(mem_aid, mem_aaddr, mem_alen, mem_asize, mem_aburst), 0);
      chk("rst_tag_valid", tag_valid, 0);
      chk("rst_tag_count", tag_count, 0);
      chk("rst_err", err_unsup, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_aready", core_aready, 1);

      // Pass-through INCR alen=3.
      mem_aready = 1'b1;
      send_req(4'h3, 32'h1000, 8'd3, 3'd2, 2'b01);
      @(negedge clk);
      chk("pt_mem_avalid", mem_avalid, 1);
      chk("pt_mem_alen", mem_alen, 3);
      chk("pt_mem_aaddr", mem_aaddr, 32'h1000);
      chk("pt_aready_low", core_aready, 0);
      @(negedge clk);
      chk("pt_aready_back", core_aready, 1);
      chk("pt_tag_split", tag_split, 0);
      @(posedge clk); #1 tag_ready = 1'b1;
      @(posedge clk); #1 tag_ready = 1'b0;

      // Split INCR alen=15, size=3: 0x2000 then 0x2040.
      send_req(4'h5, 32'h2000, 8'd15, 3'd3, 2'b01);
      idle_cycles(4);
      chk("split_tag", tag_split, 1);
      chk("split_count", tag_count, 1);
      @(posedge clk); #1 tag_ready = 1'b1;
      @(posedge clk); #1 tag_ready = 1'b0;

      // Backpressure: 5 stalled cycles in SEND0, 3 in SEND1.
      mem_aready = 1'b0;
      hs0 = hs_cnt;
      send_req(4'h9, 32'hFFFF_FFC0, 8'd15, 3'd3, 2'b01);
      idle_cycles(5);
      @(posedge clk); #1 mem_aready = 1'b1;
      @(posedge clk); #1 mem_aready = 1'b0;
      idle_cycles(3);
      @(posedge clk); #1 mem_aready = 1'b1;
      idle_cycles(4);
      chk("bp_handshakes", hs_cnt - hs0, 2);
      tag_ready = 1'b1;
      idle_cycles(2);
      tag_ready = 1'b0;

      // FIFO full: 8 requests without popping, ninth blocked until one pop.
      for (int i = 0; i < DEPTH; i++)
         send_req(4'($urandom_range(0, 15)), $urandom, 8'($urandom_range(0, 15)), 3'($urandom_range(0, 3)), 2'b01);
      idle_cycles(3);
      chk("full_count", tag_count, DEPTH);
      @(posedge clk); #1;
      core_aid = 4'hA; core_aaddr = 32'h3000; core_alen = 8'd1; core_asize = 3'd2; core_aburst = 2'b01;
      core_avalid = 1'b1;
      idle_cycles(3);
      chk("full_blocked", core_aready, 0);
      @(posedge clk); #1 tag_ready = 1'b1;
      @(posedge clk); #1 tag_ready = 1'b0;
      wait_accept();
      idle_cycles(3);
      chk("full_refill", tag_count, DEPTH);
      tag_ready = 1'b1;
      idle_cycles(DEPTH + 2);
      tag_ready = 1'b0;

      // Unsupported WRAP alen=15: passed through, sticky error.
      send_req(4'h2, 32'h4000, 8'd15, 3'd2, 2'b10);
      idle_cycles(3);
      chk("unsup_err", err_unsup, 1);
      chk("unsup_tag", tag_split, 0);
      send_req(4'h2, 32'h4100, 8'd2, 3'd2, 2'b01);
      idle_cycles(3);
      chk("unsup_sticky", err_unsup, 1);

      // Randomized traffic with random backpressure.
      rand_mode = 1'b1;
      for (int i = 0; i < 60; i++) begin
         logic [1:0] b;
         logic [7:0] l;
         b = 2'($urandom_range(0, 2));
         l = ($urandom_range(0, 2) == 0) ? 8'd15 : 8'($urandom_range(0, 15));
         send_req(4'($urandom_range(0, 15)), $urandom, l, 3'($urandom_range(0, 7)), b);
      end
      rand_mode = 1'b0;
      @(posedge clk); #2;
      mem_aready = 1'b1; tag_ready = 1'b1;
      idle_cycles(20);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_tags_drained", tag_count, 0);

      // Reset in SEND1 drops the pending sub-burst and all tags.
      tag_ready = 1'b0;
      mem_aready = 1'b0;
      send_req(4'h7, 32'h5000, 8'd15, 3'd2, 2'b01);
      @(posedge clk); #1 mem_aready = 1'b1;
      @(posedge clk); #1 mem_aready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_avalid", mem_avalid, 0);
      chk("midrst_count", tag_count, 0);
      chk("midrst_err", err_unsup, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      mem_aready = 1'b1;
      hs0 = hs_cnt;
      send_req(4'h1, 32'h6000, 8'd15, 3'd1, 2'b01);
      idle_cycles(4);
      chk("postrst_handshakes", hs_cnt - hs0, 2);
      chk("postrst_tag", tag_split, 1);
      chk("postrst_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
